// File: rtl/vga_timing_gen.sv
// Raster timing generator: pixel-rate divider, X/Y position counters, sync and
// active levels through a tick-advanced delay line, plus line/frame start pulses.
module vga_timing_gen #(
  parameter int TOTAL_COL  = 800,
  parameter int TOTAL_ROW  = 525,
  parameter int ACTIVE_COL = 640,
  parameter int ACTIVE_ROW = 480,
  parameter int H_F_PORCH  = 16,
  parameter int H_B_PORCH  = 48,
  parameter int V_F_PORCH  = 10,
  parameter int V_B_PORCH  = 33,
  parameter bit H_SYNC_POL = 1'b0,
  parameter bit V_SYNC_POL = 1'b0,
  parameter int CLK_DIV    = 1,
  parameter int DELAY      = 0,
  parameter int CNT_W      = 10
) (
  input  logic             i_Clk,
  input  logic             i_Reset,
  input  logic             i_Enable,
  output logic             o_Pix_En,
  output logic [CNT_W-1:0] o_X_Cursor,
  output logic [CNT_W-1:0] o_Y_Cursor,
  output logic             o_H_Sync,
  output logic             o_V_Sync,
  output logic             o_Active,
  output logic             o_Line_Start,
  output logic             o_Frame_Start
);

  localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int PIPE_N = DELAY + 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] X_LAST   = CNT_W'(TOTAL_COL - 1);
  localparam logic [CNT_W-1:0] Y_LAST   = CNT_W'(TOTAL_ROW - 1);
  localparam logic [CNT_W-1:0] X_ACT    = CNT_W'(ACTIVE_COL);
  localparam logic [CNT_W-1:0] Y_ACT    = CNT_W'(ACTIVE_ROW);
  localparam logic [CNT_W-1:0] HS_BEG   = CNT_W'(ACTIVE_COL + H_F_PORCH);
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(TOTAL_COL - H_B_PORCH - 1);
  localparam logic [CNT_W-1:0] VS_BEG   = CNT_W'(ACTIVE_ROW + V_F_PORCH);
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(TOTAL_ROW - V_B_PORCH - 1);

  function automatic logic in_window(input logic [CNT_W-1:0] pos,
                                     input logic [CNT_W-1:0] lo,
                                     input logic [CNT_W-1:0] hi);
    return (pos >= lo) && (pos <= hi);
  endfunction

  function automatic logic sync_level(input logic asserted, input logic pol);
    return asserted ? pol : ~pol;
  endfunction

  logic [DIV_W-1:0]  r_div;
  logic [CNT_W-1:0]  r_x;
  logic [CNT_W-1:0]  r_y;
  logic              r_pix_en;
  logic              r_line_start;
  logic              r_frame_start;
  logic [PIPE_N-1:0] r_hs_p;
  logic [PIPE_N-1:0] r_vs_p;
  logic [PIPE_N-1:0] r_act_p;

  logic              w_tick;
  logic              w_x_wrap;
  logic              w_y_wrap;
  logic [CNT_W-1:0]  w_x_nxt;
  logic [CNT_W-1:0]  w_y_nxt;
  logic              w_hs_nxt;
  logic              w_vs_nxt;
  logic              w_act_nxt;

  // The tick is the last divider count, so CLK_DIV=1 ticks on every enabled edge.
  assign w_tick   = i_Enable && (r_div == DIV_LAST);
  assign w_x_wrap = (r_x == X_LAST);
  assign w_y_wrap = (r_y == Y_LAST);
  assign w_x_nxt  = w_x_wrap ? '0 : r_x + 1'b1;
  assign w_y_nxt  = w_x_wrap ? (w_y_wrap ? '0 : r_y + 1'b1) : r_y;

  assign w_hs_nxt  = sync_level(in_window(w_x_nxt, HS_BEG, HS_END), H_SYNC_POL);
  assign w_vs_nxt  = sync_level(in_window(w_y_nxt, VS_BEG, VS_END), V_SYNC_POL);
  assign w_act_nxt = (w_x_nxt < X_ACT) && (w_y_nxt < Y_ACT);

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      r_div <= '0;
    end else if (i_Enable) begin
      r_div <= w_tick ? '0 : r_div + 1'b1;
    end
  end

  // Position counters park on the last pixel so the first tick lands on (0,0).
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      r_x <= X_LAST;
      r_y <= Y_LAST;
    end else if (w_tick) begin
      r_x <= w_x_nxt;
      r_y <= w_y_nxt;
    end
  end

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      r_pix_en      <= 1'b0;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_pix_en      <= w_tick;
      r_line_start  <= w_tick && (w_x_nxt == '0);
      r_frame_start <= w_tick && (w_x_nxt == '0) && (w_y_nxt == '0);
    end
  end

  // Stage 0 holds the level for the new position; stage DELAY drives the pins.
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      r_hs_p  <= {PIPE_N{~H_SYNC_POL}};
      r_vs_p  <= {PIPE_N{~V_SYNC_POL}};
      r_act_p <= '0;
    end else if (w_tick) begin
      r_hs_p  <= PIPE_N'({r_hs_p, w_hs_nxt});
      r_vs_p  <= PIPE_N'({r_vs_p, w_vs_nxt});
      r_act_p <= PIPE_N'({r_act_p, w_act_nxt});
    end
  end

  assign o_Pix_En      = r_pix_en;
  assign o_X_Cursor    = r_x;
  assign o_Y_Cursor    = r_y;
  assign o_H_Sync      = r_hs_p[DELAY];
  assign o_V_Sync      = r_vs_p[DELAY];
  assign o_Active      = r_act_p[DELAY];
  assign o_Line_Start  = r_line_start;
  assign o_Frame_Start = r_frame_start;

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset; all other behaviour is synchronous to the rising edge of i_Clk.
REQ-002 Parameter TOTAL_COL, default 800, SHALL set the total columns per line.
REQ-003 Parameter TOTAL_ROW, default 525, SHALL set the total rows per frame.
REQ-004 Parameter ACTIVE_COL, default 640, SHALL set the visible columns.
REQ-005 Parameter ACTIVE_ROW, default 480, SHALL set the visible rows.
REQ-006 Parameters H_F_PORCH, H_B_PORCH, V_F_PORCH and V_B_PORCH, defaults 16, 48, 10 and 33, SHALL set the porch lengths in pixels and lines.
REQ-007 Parameters H_SYNC_POL and V_SYNC_POL, default 0 for each, SHALL set the asserted level of each sync; 0 means active-low.
REQ-008 Parameter CLK_DIV, default 1, legal range 1 or more, SHALL set the number of i_Clk cycles per pixel.
REQ-009 Parameter DELAY, default 0, SHALL set the pixel-tick delay applied to the sync and active outputs.
REQ-010 Parameter CNT_W, default 10, SHALL set the counter width; 2^CNT_W SHALL be at least max(TOTAL_COL, TOTAL_ROW).
REQ-011 Port i_Clk SHALL be input, 1 bit: the system clock.
REQ-012 Port i_Reset SHALL be input, 1 bit: the asynchronous active-high reset.
REQ-013 Port i_Enable SHALL be input, 1 bit: when low, all timing state is frozen.
REQ-014 Port o_Pix_En SHALL be output, 1 bit: a one-clock strobe per pixel.
REQ-015 Ports o_X_Cursor and o_Y_Cursor SHALL be outputs, CNT_W bits each: the current column and row.
REQ-016 Ports o_H_Sync and o_V_Sync SHALL be outputs, 1 bit each: the sync signals at the configured polarity.
REQ-017 Port o_Active SHALL be output, 1 bit: high while in the visible area.
REQ-018 Ports o_Line_Start and o_Frame_Start SHALL be outputs, 1 bit each: one-clock pulses.

Function
REQ-019 A divider SHALL count 0 to CLK_DIV-1 while i_Enable is high; the clock edge on which it holds CLK_DIV-1 is a pixel tick, and the divider wraps to 0 there.
REQ-020 On a pixel tick, X SHALL increment; at TOTAL_COL-1, X SHALL wrap to 0 and Y SHALL increment; at TOTAL_ROW-1 with X wrapping, Y SHALL wrap to 0.
REQ-021 All outputs SHALL be registered; o_Pix_En SHALL be high exactly in the clock cycle in which the new X and Y values are first visible.
REQ-022 Horizontal sync SHALL be asserted when X is in [ACTIVE_COL+H_F_PORCH, TOTAL_COL-H_B_PORCH-1]; otherwise it SHALL be at the inverse level.
REQ-023 Vertical sync SHALL be asserted when Y is in [ACTIVE_ROW+V_F_PORCH, TOTAL_ROW-V_B_PORCH-1]; otherwise it SHALL be at the inverse level.
REQ-024 Active SHALL be high when X < ACTIVE_COL and Y < ACTIVE_ROW.
REQ-025 With DELAY=0, o_H_Sync, o_V_Sync and o_Active SHALL match the displayed X and Y in the same cycle.
REQ-026 With DELAY=N, those three outputs SHALL be passed through an N-stage shift register that advances only on pixel ticks; they then correspond to the position N ticks earlier.
REQ-027 o_Line_Start SHALL pulse alongside o_Pix_En when the new X equals 0.
REQ-028 o_Frame_Start SHALL pulse alongside o_Pix_En when the new X and Y both equal 0.
REQ-029 Both pulses SHALL be undelayed.
REQ-030 When i_Enable is low, the divider, counters and delay line SHALL hold, o_Pix_En and both pulses SHALL be 0, and the level outputs SHALL hold.
REQ-031 When i_Enable rises, operation SHALL resume from the held state.
REQ-032 With CLK_DIV=1, o_Pix_En SHALL be high on every enabled cycle.
REQ-033 The pixel-tick and wrap logic SHALL need no special case for CLK_DIV=1.
REQ-034 Parameter sets that violate ACTIVE+F_PORCH+B_PORCH < TOTAL on either axis are illegal, and behaviour with them is undefined.

Reset
REQ-035 Asserting i_Reset SHALL immediately force the divider to 0, X to TOTAL_COL-1 and Y to TOTAL_ROW-1.
REQ-036 During reset, o_Pix_En, o_Active, o_Line_Start and o_Frame_Start SHALL be 0.
REQ-037 During reset, both syncs and every delay stage SHALL be at their deasserted levels.
REQ-038 After reset is released, the first pixel tick SHALL produce X=0, Y=0, with o_Line_Start and o_Frame_Start both high.
REQ-039 Reset asserted in the middle of a frame SHALL abandon that frame with no partial pulses.

Verification
REQ-040 Defaults, release reset: the first o_Pix_En is in the cycle after release; X=0, Y=0, Frame_Start=1, Active=1, H_Sync=1, V_Sync=1.
REQ-041 Defaults, run 1 line: H_Sync is low for exactly 96 ticks, X=656..751; Active is high for 640 ticks; the next Line_Start comes at tick 800.
REQ-042 Defaults, run 1 frame: V_Sync is low for lines 490..491; Frame_Start fires again after exactly 420000 ticks; Y wraps from 524 to 0.
REQ-043 CLK_DIV=2 and DELAY=2: o_Pix_En is high every second clock; the H_Sync falling edge is seen while X=658; the Frame_Start period is 840000 clocks.
REQ-044 Drop i_Enable for 7 clocks mid-line: X, Y and the syncs hold, o_Pix_En stays 0, and counting resumes at X+1.
REQ-045 Assert i_Reset asynchronously between clock edges at X=300, Y=200: outputs go to reset values before the next edge, and the first tick after release gives Frame_Start with X=0, Y=0.
